femtorv_lsu: RTL and testbench
==============================

Name: femtorv_lsu

Overview:
- Load/store unit directly upstream of the dual-port byte-enable word RAM; drives one RAM port (addr, be, data_in, we) and consumes its registered data_out.
- Converts RV32I byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word address, byte enables and lane-replicated write data.
- Aligns and sign/zero-extends read data, detects misaligned or illegal accesses, and returns one response per request over a valid/ready handshake.

Parameters:
- ADDRESS_WIDTH, 10, RAM word-address width; the byte address uses bits [ADDRESS_WIDTH+1:0], and upper bits are ignored (wrap).

Ports:
- clk  in  1  clock, all state on posedge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  misaligned or illegal funct3.
- mem_addr  out  ADDRESS_WIDTH  word address = req_addr[ADDRESS_WIDTH+1:2].
- mem_be  out  4  byte enables.
- mem_wdata  out  32  replicated write data.
- mem_we  out  1  write strobe.
- mem_rdata  in  32  RAM read data, valid one cycle after the address edge.

Behaviour:
- FSM states: IDLE, LOAD_WAIT, RESP.
- Reset (async, resetn=0): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, latched funct3/offset=0.
- req_ready = (state==IDLE). mem_* outputs are combinational from the request while in IDLE.
- mem_we = IDLE && req_valid && req_we && legal; otherwise mem_we=0 and mem_be=0. mem_addr is driven in IDLE regardless.
- Legality:
  - Illegal: funct3 011/110/111; stores with funct3[2]=1.
  - Misaligned: H with addr[0]=1; W with addr[1:0]!=0.
  - Any illegal or misaligned request: no write, go to RESP with rsp_err=1 and rsp_rdata=0.
- Byte enables and write data:
  - B: be=1<<addr[1:0], wdata={4{wdata[7:0]}}.
  - H: be= addr[1] ? 4'b1100 : 4'b0011, wdata={2{wdata[15:0]}}.
  - W: be=4'b1111, wdata=wdata.
- Store: accepted at edge N (write occurs at the same edge in the RAM). Response rsp_valid=1 from cycle N+1, rsp_err=0, rsp_rdata=0.
- Load: accepted at edge N; latch funct3 and addr[1:0]; go to LOAD_WAIT.
  - In LOAD_WAIT, select mem_rdata byte/half by the latched offset, sign-extend (B/H) or zero-extend (BU/HU), register into rsp_rdata, go to RESP.
  - rsp_valid is first high in cycle N+2.
- RESP: hold rsp_valid and data stable until rsp_ready. On handshake, return to IDLE; a new request is accepted no earlier than the following cycle. Throughput: store 1 per 2 cycles, load 1 per 3 cycles minimum.
- Address wrap: req_addr bits above ADDRESS_WIDTH+1 are ignored, with no error.
- Reset mid-operation: pending load/response is discarded. A store already issued is not undone. No output glitch beyond the async clear.
- While not in IDLE, req_valid is ignored and the request must be held by the source.

Decomposition:
- Package femtorv_lsu_pkg:
  - state enum lsu_state_t.
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - function for byte-enable generation.
- Sub-module femtorv_load_align: combinational mem_rdata + offset + funct3 -> extended 32-bit result.

Test Plan:
- Preload RAM word 1 = 0xDEADBEEF. LB @0x7 -> rsp_rdata=0xFFFFFFDE, rsp_err=0, rsp_valid in cycle N+2.
- Same word: LBU @0x5 -> 0x000000BE; LH @0x6 -> 0xFFFFDEAD; LHU @0x4 -> 0x0000BEEF.
- SB @0x5 with wdata=0x12345677 -> mem_be=0010, mem_wdata=0x77777777, mem_we=1 for one cycle. Then LW @0x4 -> 0xDEAD77EF.
- LW @0x6 and SH @0x3 -> mem_we never 1, rsp_err=1, rsp_rdata=0. funct3=011 load -> rsp_err=1.
- LW response with rsp_ready=0 for 3 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 throughout. Returns to IDLE the cycle after rsp_ready=1.
- Assert resetn=0 in LOAD_WAIT -> rsp_valid=0 immediately, state IDLE, req_ready=1 after release. Next LW @0x4 returns correct data.

Source files
------------

// File: rtl/femtorv_lsu_pkg.sv
// Shared types, funct3 encodings and access helpers for the femtorv load/store unit.
package femtorv_lsu_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE      = 2'd0,
        LSU_LOAD_WAIT = 2'd1,
        LSU_RESP      = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte lanes touched by an access of the given size at the given byte offset.
    function automatic logic [3:0] lsu_byte_en(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b00:   return 4'b0001 << offset;
            2'b01:   return offset[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // True when the funct3 encoding is legal for the direction and the offset is naturally aligned.
    function automatic logic lsu_access_ok(input logic is_store, input logic [2:0] funct3,
                                           input logic [1:0] offset);
        logic legal;
        logic aligned;
        legal   = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                  (!is_store && ((funct3 == F3_BU) || (funct3 == F3_HU)));
        aligned = !((funct3[1:0] == 2'b01) && offset[0]) &&
                  !((funct3[1:0] == 2'b10) && (offset != 2'b00));
        return legal && aligned;
    endfunction

endpackage

// File: rtl/femtorv_lsu_if.sv
// Request/response handshake plus RAM-port bundle between a core, the LSU and the word RAM.
interface femtorv_lsu_if #(
    parameter int ADDRESS_WIDTH = 10
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [2:0]               req_funct3;
    logic [31:0]              req_addr;
    logic [31:0]              req_wdata;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [31:0]              rsp_rdata;
    logic                     rsp_err;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [3:0]               mem_be;
    logic [31:0]              mem_wdata;
    logic                     mem_we;
    logic [31:0]              mem_rdata;

    // Requester side; it also stands in for the RAM by supplying mem_rdata.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_be, mem_wdata, mem_we
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_be, mem_wdata, mem_we
    );
endinterface

// File: rtl/femtorv_load_align.sv
// Picks the addressed byte/half out of a RAM word and sign- or zero-extends it.
module femtorv_load_align
    import femtorv_lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [7:0]  lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = mem_rdata[8*gi +: 8];
    end

    assign sel_byte = lane[offset];
    assign sel_half = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_data = mem_rdata;
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'h000000, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'h0000, sel_half};
            default: load_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/femtorv_lsu.sv
// RV32I load/store unit: one request in, one response out, driving a single byte-enable RAM port.
module femtorv_lsu
    import femtorv_lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic         clk,
    input  logic         resetn,
    femtorv_lsu_if.slave bus
);

    localparam logic [1:0] ST_IDLE      = LSU_IDLE;
    localparam logic [1:0] ST_LOAD_WAIT = LSU_LOAD_WAIT;
    localparam logic [1:0] ST_RESP      = LSU_RESP;

    logic [1:0]  state_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  offset_reg;
    logic        rsp_valid_reg;
    logic [31:0] rsp_rdata_reg;
    logic        rsp_err_reg;

    logic        idle;
    logic        access_ok;
    logic        store_fire;
    logic [31:0] wdata_rep;
    logic [31:0] load_data;

    assign idle       = (state_reg == ST_IDLE);
    assign access_ok  = lsu_access_ok(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
    assign store_fire = idle && bus.req_valid && bus.req_we && access_ok;

    // Byte address bits above the RAM's reach simply wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:ADDRESS_WIDTH+2];

    always_comb begin
        wdata_rep = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00:   wdata_rep = {4{bus.req_wdata[7:0]}};
            2'b01:   wdata_rep = {2{bus.req_wdata[15:0]}};
            default: wdata_rep = bus.req_wdata;
        endcase
    end

    assign bus.req_ready = idle;
    assign bus.mem_addr  = bus.req_addr[ADDRESS_WIDTH+1:2];
    assign bus.mem_we    = store_fire;
    assign bus.mem_be    = store_fire ? lsu_byte_en(bus.req_funct3, bus.req_addr[1:0]) : 4'b0000;
    assign bus.mem_wdata = wdata_rep;

    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;

    femtorv_load_align u_align (
        .mem_rdata (bus.mem_rdata),
        .offset    (offset_reg),
        .funct3    (funct3_reg),
        .load_data (load_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= ST_IDLE;
            funct3_reg    <= 3'b000;
            offset_reg    <= 2'b00;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'h0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        if (!access_ok) begin
                            state_reg     <= ST_RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= 1'b1;
                            rsp_rdata_reg <= 32'h0;
                        end else if (bus.req_we) begin
                            // The RAM commits the write on this same edge.
                            state_reg     <= ST_RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= 1'b0;
                            rsp_rdata_reg <= 32'h0;
                        end else begin
                            state_reg  <= ST_LOAD_WAIT;
                            funct3_reg <= bus.req_funct3;
                            offset_reg <= bus.req_addr[1:0];
                        end
                    end
                end
                ST_LOAD_WAIT: begin
                    state_reg     <= ST_RESP;
                    rsp_valid_reg <= 1'b1;
                    rsp_err_reg   <= 1'b0;
                    rsp_rdata_reg <= load_data;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state_reg     <= ST_IDLE;
                        rsp_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    rsp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_femtorv_lsu.sv
// Directed bench for femtorv_lsu with a behavioural byte-enable RAM behind the memory port.
module tb_femtorv_lsu;

    localparam int AW = 10;

    logic clk;
    logic resetn;
    int   errors;
    int   checks;

    femtorv_lsu_if #(.ADDRESS_WIDTH(AW)) bus ();

    femtorv_lsu #(.ADDRESS_WIDTH(AW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word RAM with a registered read port that returns the pre-write contents.
    logic [31:0] ram [1 << AW];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (bus.mem_we && bus.mem_be[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    // Presents a request, holds it until the response arrives, then acknowledges it.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rdata, output logic err,
                          output int lat, output int we_cyc, output logic [3:0] be_s,
                          output logic [31:0] wd_s, output logic [AW-1:0] addr_s);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        #1;
        be_s   = bus.mem_be;
        wd_s   = bus.mem_wdata;
        addr_s = bus.mem_addr;
        we_cyc = bus.mem_we ? 1 : 0;
        @(posedge clk); #1;
        lat = 1;
        if (bus.mem_we) we_cyc++;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (bus.mem_we) we_cyc++;
        end
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        $display("txn we=%0b f3=%03b addr=%08h wdata=%08h -> rdata=%08h err=%0b lat=%0d we_cycles=%0d",
                 we, f3, addr, wd, rdata, err, lat, we_cyc);
    endtask

    task automatic test_reset();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%0b want=0", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got=%08h want=00000000", bus.rsp_rdata); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%0b want=0", bus.rsp_err); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%0b want=1", bus.req_ready); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%0b want=0", bus.mem_we); end
    endtask

    task automatic test_loads();
        logic [31:0] rd; logic er; int lat; int wc; logic [3:0] be; logic [31:0] wd; logic [AW-1:0] ad;
        logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] adrs [4] = '{32'h7, 32'h5, 32'h6, 32'h4};
        logic [31:0] exps [4] = '{32'hFFFFFFDE, 32'h000000BE, 32'hFFFFDEAD, 32'h0000BEEF};
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, f3s[i], adrs[i], 32'h0, rd, er, lat, wc, be, wd, ad);
            checks++; if (rd !== exps[i]) begin errors++; $display("FAIL load%0d_rdata got=%08h want=%08h", i, rd, exps[i]); end
            checks++; if (er !== 1'b0) begin errors++; $display("FAIL load%0d_err got=%0b want=0", i, er); end
            checks++; if (lat !== 2) begin errors++; $display("FAIL load%0d_latency got=%0d want=2", i, lat); end
            checks++; if (wc !== 0) begin errors++; $display("FAIL load%0d_mem_we got=%0d want=0", i, wc); end
        end
    endtask

    task automatic test_store();
        logic [31:0] rd; logic er; int lat; int wc; logic [3:0] be; logic [31:0] wd; logic [AW-1:0] ad;
        do_req(1'b1, 3'b000, 32'h5, 32'h12345677, rd, er, lat, wc, be, wd, ad);
        checks++; if (be !== 4'b0010) begin errors++; $display("FAIL sb_mem_be got=%04b want=0010", be); end
        checks++; if (wd !== 32'h77777777) begin errors++; $display("FAIL sb_mem_wdata got=%08h want=77777777", wd); end
        checks++; if (ad !== 10'd1) begin errors++; $display("FAIL sb_mem_addr got=%0d want=1", ad); end
        checks++; if (wc !== 1) begin errors++; $display("FAIL sb_we_cycles got=%0d want=1", wc); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL sb_latency got=%0d want=1", lat); end
        checks++; if ({er, rd} !== 33'h0) begin errors++; $display("FAIL sb_rsp got err=%0b rdata=%08h want 0/00000000", er, rd); end
        do_req(1'b1, 3'b001, 32'h22, 32'hABCD1234, rd, er, lat, wc, be, wd, ad);
        checks++; if ({be, wd} !== {4'b1100, 32'h12341234}) begin errors++; $display("FAIL sh_lanes got be=%04b wdata=%08h want 1100/12341234", be, wd); end
        do_req(1'b1, 3'b010, 32'h24, 32'hCAFEF00D, rd, er, lat, wc, be, wd, ad);
        checks++; if ({be, wd} !== {4'b1111, 32'hCAFEF00D}) begin errors++; $display("FAIL sw_lanes got be=%04b wdata=%08h want 1111/cafef00d", be, wd); end
        do_req(1'b0, 3'b010, 32'h4, 32'h0, rd, er, lat, wc, be, wd, ad);
        checks++; if (rd !== 32'hDEAD77EF) begin errors++; $display("FAIL lw_after_sb got=%08h want=dead77ef", rd); end
        do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat, wc, be, wd, ad);
        checks++; if (rd !== 32'h12340000) begin errors++; $display("FAIL lw_after_sh got=%08h want=12340000", rd); end
        do_req(1'b0, 3'b001, 32'h24, 32'h0, rd, er, lat, wc, be, wd, ad);
        checks++; if (rd !== 32'hFFFFF00D) begin errors++; $display("FAIL lh_after_sw got=%08h want=fffff00d", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat; int wc; logic [3:0] be; logic [31:0] wd; logic [AW-1:0] ad;
        logic        wes  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [2:0]  f3s  [5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b010};
        logic [31:0] adrs [5] = '{32'h6, 32'h3, 32'h4, 32'h4, 32'h5};
        for (int i = 0; i < 5; i++) begin
            do_req(wes[i], f3s[i], adrs[i], 32'hFFFFFFFF, rd, er, lat, wc, be, wd, ad);
            checks++; if (er !== 1'b1) begin errors++; $display("FAIL err%0d_rsp_err got=%0b want=1", i, er); end
            checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err%0d_rsp_rdata got=%08h want=00000000", i, rd); end
            checks++; if (wc !== 0 || be !== 4'b0000) begin errors++; $display("FAIL err%0d_no_write got we_cycles=%0d be=%04b want 0/0000", i, wc, be); end
            checks++; if (lat !== 1) begin errors++; $display("FAIL err%0d_latency got=%0d want=1", i, lat); end
        end
        do_req(1'b0, 3'b010, 32'h4, 32'h0, rd, er, lat, wc, be, wd, ad);
        checks++; if (rd !== 32'hDEAD77EF) begin errors++; $display("FAIL word_untouched got=%08h want=dead77ef", rd); end
    endtask

    task automatic test_backpressure();
        int guard;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h4;
        @(posedge clk); #1;
        guard = 0;
        while (!bus.rsp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_timeout got=%0b want=1", bus.rsp_valid); end
        for (int i = 0; i < 3; i++) begin
            checks++; if ({bus.rsp_valid, bus.req_ready, bus.rsp_rdata} !== {1'b1, 1'b0, 32'hDEAD77EF})
                begin errors++; $display("FAIL bp_hold%0d got valid=%0b ready=%0b rdata=%08h want 1/0/dead77ef", i, bus.rsp_valid, bus.req_ready, bus.rsp_rdata); end
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        checks++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin errors++; $display("FAIL bp_release got valid=%0b ready=%0b want 0/1", bus.rsp_valid, bus.req_ready); end
        $display("txn backpressured LW @00000004 released");
    endtask

    task automatic test_addr_wrap();
        logic [31:0] rd; logic er; int lat; int wc; logic [3:0] be; logic [31:0] wd; logic [AW-1:0] ad;
        do_req(1'b0, 3'b010, 32'h10001004, 32'h0, rd, er, lat, wc, be, wd, ad);
        checks++; if (ad !== 10'd1) begin errors++; $display("FAIL wrap_mem_addr got=%0d want=1", ad); end
        checks++; if ({er, rd} !== {1'b0, 32'hDEAD77EF}) begin errors++; $display("FAIL wrap_rsp got err=%0b rdata=%08h want 0/dead77ef", er, rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; int wc; logic [3:0] be; logic [31:0] wd; logic [AW-1:0] ad;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h4;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL mid_in_load_wait got req_ready=%0b want=0", bus.req_ready); end
        resetn = 1'b0;
        #1;
        checks++; if ({bus.rsp_valid, bus.req_ready, bus.rsp_rdata} !== {1'b0, 1'b1, 32'h0})
            begin errors++; $display("FAIL mid_async_clear got valid=%0b ready=%0b rdata=%08h want 0/1/00000000", bus.rsp_valid, bus.req_ready, bus.rsp_rdata); end
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin errors++; $display("FAIL mid_after_release got valid=%0b ready=%0b want 0/1", bus.rsp_valid, bus.req_ready); end
        $display("txn LW @00000004 aborted by reset");
        do_req(1'b0, 3'b010, 32'h4, 32'h0, rd, er, lat, wc, be, wd, ad);
        checks++; if ({er, rd} !== {1'b0, 32'hDEAD77EF}) begin errors++; $display("FAIL mid_reload got err=%0b rdata=%08h want 0/dead77ef", er, rd); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL mid_reload_latency got=%0d want=2", lat); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
        ram[1] = 32'hDEADBEEF;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.rsp_ready  = 1'b0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_loads();
        test_store();
        test_errors();
        test_backpressure();
        test_addr_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
